// File: rtl/image_ds_pkg.sv
// ============================================================================
//  Module      : image_ds_pkg
//  Description : Shared phase encodings, requester IDs and default widths for
//                the image down-sampling datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package image_ds_pkg;

    localparam int c_addr_w = 20;
    localparam int c_data_w = 8;

    typedef enum logic [1:0] {
        PH_LOAD = 2'd0,
        PH_CALC = 2'd1,
        PH_DUMP = 2'd2
    } phase_e;

    localparam logic REQ_UART = 1'b0;
    localparam logic REQ_CALC = 1'b1;

endpackage

`default_nettype wire

// File: rtl/rd_tag_pipe.sv
// ============================================================================
//  Module      : rd_tag_pipe
//  Description : RD_LAT-deep {valid, owner} shift register that steers RAM read
//                returns to the requester that issued them.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rd_tag_pipe
    import image_ds_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_push,
    input  logic i_owner,
    output logic o_rvalid_uart,
    output logic o_rvalid_calc,
    output logic o_empty
);

    logic [RD_LAT-1:0] r_vld;
    logic [RD_LAT-1:0] r_own;
    logic              w_busy;

    generate
        if (RD_LAT == 1) begin : g_lat1
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld <= 1'b0;
                    r_own <= 1'b0;
                end else begin
                    r_vld <= i_push;
                    r_own <= i_owner;
                end
            end
            assign w_busy = 1'b0;
        end else begin : g_latn
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld <= '0;
                    r_own <= '0;
                end else begin
                    r_vld <= {r_vld[RD_LAT-2:0], i_push};
                    r_own <= {r_own[RD_LAT-2:0], i_owner};
                end
            end
            // The tag in the last stage is being delivered this cycle, so it no longer counts as in flight.
            assign w_busy = |r_vld[RD_LAT-2:0];
        end
    endgenerate

    assign o_rvalid_uart = r_vld[RD_LAT-1] & (r_own[RD_LAT-1] == REQ_UART);
    assign o_rvalid_calc = r_vld[RD_LAT-1] & (r_own[RD_LAT-1] == REQ_CALC);
    assign o_empty       = ~i_push & ~w_busy;

endmodule

`default_nettype wire

// File: rtl/image_ram_arbiter.sv
// ============================================================================
//  Module      : image_ram_arbiter
//  Description : Phase-sequenced round-robin arbiter sharing the single-port
//                image RAM between the UART loader/dumper and the compute engine.
//                Optional grant counters: define IMAGE_RAM_ARB_STAT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module image_ram_arbiter
    import image_ds_pkg::*;
#(
    parameter int ADDR_W = c_addr_w,
    parameter int DATA_W = c_data_w,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_calculation,
    input  logic              finish,
    input  logic              dump_done,
    output logic [1:0]        phase,
    input  logic              uart_req,
    input  logic              uart_we,
    input  logic [ADDR_W-1:0] uart_addr,
    input  logic [DATA_W-1:0] uart_wdata,
    output logic              uart_gnt,
    output logic              uart_rvalid,
    input  logic              calc_req,
    input  logic              calc_we,
    input  logic [ADDR_W-1:0] calc_addr,
    input  logic [DATA_W-1:0] calc_wdata,
    output logic              calc_gnt,
    output logic              calc_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              blocked,
    output logic [15:0]       stat_uart_cnt,
    output logic [15:0]       stat_calc_cnt
);

    phase_e              r_phase;
    phase_e              w_phase_nxt;
    logic                r_ptr;
    logic                r_uart_gnt;
    logic                r_calc_gnt;
    logic                r_ram_en;
    logic                r_ram_we;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [DATA_W-1:0]   r_ram_wdata;
    logic                r_blocked;

    logic                w_ok_uart;
    logic                w_ok_calc;
    logic                w_elig_uart;
    logic                w_elig_calc;
    logic                w_gnt_uart;
    logic                w_gnt_calc;
    logic                w_any_gnt;
    logic                w_pipe_empty;
    logic                w_idle;
    logic                w_rd_push;

    assign w_ok_uart   = (r_phase != PH_CALC);
    assign w_ok_calc   = (r_phase == PH_CALC);
    // Excluding the requester in its gnt cycle stops a still-held req from issuing twice.
    assign w_elig_uart = uart_req & w_ok_uart & ~r_uart_gnt;
    assign w_elig_calc = calc_req & w_ok_calc & ~r_calc_gnt;

    always_comb begin
        w_gnt_uart = 1'b0;
        w_gnt_calc = 1'b0;
        if (w_elig_uart && w_elig_calc) begin
            if (r_ptr == REQ_UART) w_gnt_uart = 1'b1;
            else                   w_gnt_calc = 1'b1;
        end else begin
            w_gnt_uart = w_elig_uart;
            w_gnt_calc = w_elig_calc;
        end
    end

    assign w_any_gnt = w_gnt_uart | w_gnt_calc;
    assign w_idle    = w_pipe_empty & ~w_any_gnt;

    always_comb begin
        w_phase_nxt = r_phase;
        if (w_idle) begin
            case (r_phase)
                PH_LOAD: if (start_calculation) w_phase_nxt = PH_CALC;
                PH_CALC: if (finish)            w_phase_nxt = PH_DUMP;
                PH_DUMP: if (dump_done)         w_phase_nxt = PH_LOAD;
                default:                        w_phase_nxt = PH_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase     <= PH_LOAD;
            r_ptr       <= REQ_UART;
            r_uart_gnt  <= 1'b0;
            r_calc_gnt  <= 1'b0;
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_blocked   <= 1'b0;
        end else begin
            r_phase    <= w_phase_nxt;
            r_uart_gnt <= w_gnt_uart;
            r_calc_gnt <= w_gnt_calc;
            r_ram_en   <= w_any_gnt;
            r_ram_we   <= (w_gnt_uart & uart_we) | (w_gnt_calc & calc_we);
            r_blocked  <= (uart_req & ~w_ok_uart) | (calc_req & ~w_ok_calc);
            if (w_any_gnt) begin
                r_ram_addr <= w_gnt_uart ? uart_addr : calc_addr;
                r_ptr      <= w_gnt_uart ? REQ_CALC : REQ_UART;
            end
            if (w_gnt_uart && uart_we) begin
                r_ram_wdata <= uart_wdata;
            end else if (w_gnt_calc && calc_we) begin
                r_ram_wdata <= calc_wdata;
            end
        end
    end

    assign w_rd_push = r_ram_en & ~r_ram_we;

    rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_push        (w_rd_push),
        .i_owner       (r_calc_gnt),
        .o_rvalid_uart (uart_rvalid),
        .o_rvalid_calc (calc_rvalid),
        .o_empty       (w_pipe_empty)
    );

`ifdef IMAGE_RAM_ARB_STAT_EN
    logic [15:0] r_stat_uart;
    logic [15:0] r_stat_calc;
    logic        w_load_entry;

    assign w_load_entry = (r_phase != PH_LOAD) && (w_phase_nxt == PH_LOAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_uart <= '0;
            r_stat_calc <= '0;
        end else if (w_load_entry) begin
            r_stat_uart <= '0;
            r_stat_calc <= '0;
        end else begin
            if (w_gnt_uart && (r_stat_uart != 16'hFFFF)) r_stat_uart <= r_stat_uart + 16'd1;
            if (w_gnt_calc && (r_stat_calc != 16'hFFFF)) r_stat_calc <= r_stat_calc + 16'd1;
        end
    end

    assign stat_uart_cnt = r_stat_uart;
    assign stat_calc_cnt = r_stat_calc;
`else
    assign stat_uart_cnt = 16'd0;
    assign stat_calc_cnt = 16'd0;
`endif

    assign phase     = r_phase;
    assign uart_gnt  = r_uart_gnt;
    assign calc_gnt  = r_calc_gnt;
    assign ram_en    = r_ram_en;
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign blocked   = r_blocked;
    assign rdata     = ram_rdata;

endmodule

`default_nettype wire
